// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexed hex driver for a common-anode multi-digit 7-segment display.
// One digit slot lasts REFRESH_DIV clocks; new values are staged in a pending
// register and only become visible at a frame boundary, so a frame never tears.
// Optional feature: define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     blank,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    // A single-digit build still needs a 1-bit index register.
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_vld;
    logic                    r_frame_wrap;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_dark;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_nibble;
    logic                    w_sel_dark;

    // Segment pattern for one hex nibble, active-low, bit0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    assign w_slot_end  = (r_div_cnt == DIV_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_onehot    = NUM_DIGITS'(1) << r_idx;

    // Per-digit darkness: the live blank input, optionally ORed with leading-zero detection.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dark
`ifdef SEVEN_SEG_LZB_EN
            if (gi == 0) begin : g_digit0
                // The least significant digit always shows, so a zero value reads "0".
                assign w_dark[gi] = blank[gi];
            end else begin : g_upper
                assign w_dark[gi] = blank[gi] | (r_disp[4*NUM_DIGITS-1:4*gi] == '0);
            end
`else
            assign w_dark[gi] = blank[gi];
`endif
        end
    endgenerate

    // Select the nibble and darkness flag of the digit currently being scanned.
    always_comb begin
        w_nibble   = 4'h0;
        w_sel_dark = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble   = r_disp[4*i +: 4];
                w_sel_dark = w_dark[i];
            end
        end
    end

    // Refresh divider: one full count per digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Digit index: advance each slot, wrap to digit 0 at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Load path: stage into pending, promote to the display only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_frame_end && load) begin
            // A load landing on the boundary is the newest value; bypass pending.
            r_disp     <= value;
            r_pend     <= value;
            r_pend_vld <= 1'b0;
        end else if (w_frame_end && r_pend_vld) begin
            r_disp     <= r_pend;
            r_pend_vld <= 1'b0;
        end else if (load) begin
            r_pend     <= value;
            r_pend_vld <= 1'b1;
        end
    end

    // Output stage: registered drive of the current digit, one cycle behind the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_wrap <= 1'b0;
            r_frame_tick <= 1'b0;
            r_an         <= '1;
            r_seg        <= 7'h7F;
        end else begin
            // The wrap flag delays the tick so it lands with the an update for digit 0.
            r_frame_wrap <= w_frame_end;
            r_frame_tick <= r_frame_wrap;
            r_an         <= w_sel_dark ? '1 : ~w_onehot;
            r_seg        <= w_sel_dark ? 7'h7F : hex_to_seg(w_nibble);
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
